// File: rtl/half_adder_if.sv
// ----------------------------------------------------------------------------
// half_adder_if
//   Signal bundle for the half_adder cell: operand/strobe inputs plus the
//   combinational, registered and statistics outputs.
//
//   Parameter
//     CNT_W      width of carry_cnt (1..32); must match the attached half_adder
//
//   Members
//     a, b       addends
//     en         capture strobe for registered outputs and counter
//     clr_cnt    synchronous clear of carry_cnt / cnt_sat
//     sum, carry combinational a^b, a&b
//     sum_q, carry_q, q_valid   registered result and one-cycle valid strobe
//     carry_cnt, cnt_sat        saturating carry-event counter and sticky flag
//
//   Modports
//     master     drives a/b/en/clr_cnt, observes results (bench / upstream)
//     slave      the half_adder itself
// ----------------------------------------------------------------------------
interface half_adder_if #(
  parameter int CNT_W = 8
);
  logic             a;
  logic             b;
  logic             en;
  logic             clr_cnt;
  logic             sum;
  logic             carry;
  logic             sum_q;
  logic             carry_q;
  logic             q_valid;
  logic [CNT_W-1:0] carry_cnt;
  logic             cnt_sat;

  modport master (
    output a, b, en, clr_cnt,
    input  sum, carry, sum_q, carry_q, q_valid, carry_cnt, cnt_sat
  );

  modport slave (
    input  a, b, en, clr_cnt,
    output sum, carry, sum_q, carry_q, q_valid, carry_cnt, cnt_sat
  );
endinterface

// File: rtl/half_adder.sv
// ----------------------------------------------------------------------------
// half_adder
//   1-bit half adder cell (sum = a ^ b, carry = a & b) with zero-latency
//   combinational outputs, a registered copy of the result with a valid
//   strobe, and an optional saturating carry-event counter.
//
//   Parameter
//     CNT_W      width of carry_cnt (1..32)
//
//   Ports
//     clk        rising-edge clock
//     rst        synchronous reset, active-high; clears every register and
//                has priority over en and clr_cnt
//     bus        half_adder_if.slave bundle (a, b, en, clr_cnt in;
//                sum, carry, sum_q, carry_q, q_valid, carry_cnt, cnt_sat out)
//
//   Configuration macro
//     HALF_ADDER_STATS_EN  defined: carry counter present.
//                          undefined: carry_cnt and cnt_sat tied to 0,
//                          clr_cnt ignored; ports unchanged.
// ----------------------------------------------------------------------------
module half_adder #(
  parameter int CNT_W = 8
) (
  input  logic          clk,
  input  logic          rst,
  half_adder_if.slave   bus
);

  // Combinational cell: no dependence on clk, rst or en.
  logic sum_c;
  logic carry_c;

  assign sum_c     = bus.a ^ bus.b;
  assign carry_c   = bus.a & bus.b;
  assign bus.sum   = sum_c;
  assign bus.carry = carry_c;

  // Registered copy of the result.
  logic sum_r;
  logic carry_r;
  logic valid_r;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_r   <= 1'b0;
      carry_r <= 1'b0;
      valid_r <= 1'b0;
    end else begin
      valid_r <= bus.en;
      if (bus.en) begin
        sum_r   <= sum_c;
        carry_r <= carry_c;
      end
    end
  end

  assign bus.sum_q   = sum_r;
  assign bus.carry_q = carry_r;
  assign bus.q_valid = valid_r;

`ifdef HALF_ADDER_STATS_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt;
  logic             sat_r;
  logic             sat_nxt;

  // Next-state for the counter. clr_cnt wins over a same-cycle increment;
  // cnt_sat rises on the very edge the count first lands on all-ones.
  // NOTE: every always_comb output gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    cnt_nxt = cnt_r;
    sat_nxt = sat_r;
    if (bus.clr_cnt) begin
      cnt_nxt = '0;
      sat_nxt = 1'b0;
    end else if (bus.en && carry_c && (cnt_r != CNT_MAX)) begin
      cnt_nxt = cnt_r + CNT_W'(1);
      if (cnt_nxt == CNT_MAX) begin
        sat_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= '0;
      sat_r <= 1'b0;
    end else begin
      cnt_r <= cnt_nxt;
      sat_r <= sat_nxt;
    end
  end

  assign bus.carry_cnt = cnt_r;
  assign bus.cnt_sat   = sat_r;
`else
  // Statistics removed: outputs tied off, clr_cnt deliberately unused.
  logic unused_clr_cnt;
  assign unused_clr_cnt = bus.clr_cnt;

  assign bus.carry_cnt = '0;
  assign bus.cnt_sat   = 1'b0;
`endif

endmodule

// File: tb/tb_half_adder.sv
// ----------------------------------------------------------------------------
// tb_half_adder
//   Directed bench for half_adder with CNT_W = 2: combinational sweep with
//   the clock idle, then a table of per-edge vectors covering reset, capture,
//   hold, back-to-back capture, counter saturation, clear priority and reset
//   mid-operation. Counter expectations follow HALF_ADDER_STATS_EN.
// ----------------------------------------------------------------------------
module tb_half_adder;

  localparam int CNT_W = 2;

`ifdef HALF_ADDER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  bit   clk_run = 1'b0;

  half_adder_if #(.CNT_W(CNT_W)) bus ();

  half_adder #(.CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always begin
    #5;
    if (clk_run) clk = ~clk;
  end

  int n_vec  = 0;
  int n_fail = 0;

  task automatic check(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s [%0d]: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  typedef struct {
    logic rst, a, b, en, clr;
    logic sum, carry;
    logic sq, cq, v;
    int   cnt;
    logic sat;
  } vec_t;

  vec_t vecs[16];

  function automatic int ec(input int x);
    return STATS ? x : 0;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //            rst a  b  en clr  sum car  sq cq v   cnt      sat
    vecs[0]  = '{1, 1, 1, 1, 0,   0, 1,   0, 0, 0, ec(0), 1'(ec(0))};
    vecs[1]  = '{1, 1, 1, 1, 0,   0, 1,   0, 0, 0, ec(0), 1'(ec(0))};
    vecs[2]  = '{0, 1, 0, 1, 0,   1, 0,   1, 0, 1, ec(0), 1'(ec(0))};
    vecs[3]  = '{0, 1, 0, 0, 0,   1, 0,   1, 0, 0, ec(0), 1'(ec(0))};
    vecs[4]  = '{0, 0, 1, 0, 0,   1, 0,   1, 0, 0, ec(0), 1'(ec(0))};
    vecs[5]  = '{0, 1, 1, 1, 0,   0, 1,   0, 1, 1, ec(1), 1'(ec(0))};
    vecs[6]  = '{0, 1, 1, 1, 0,   0, 1,   0, 1, 1, ec(2), 1'(ec(0))};
    vecs[7]  = '{0, 1, 1, 1, 0,   0, 1,   0, 1, 1, ec(3), 1'(ec(1))};
    vecs[8]  = '{0, 1, 1, 1, 0,   0, 1,   0, 1, 1, ec(3), 1'(ec(1))};
    vecs[9]  = '{0, 1, 1, 1, 1,   0, 1,   0, 1, 1, ec(0), 1'(ec(0))};
    vecs[10] = '{0, 1, 1, 1, 0,   0, 1,   0, 1, 1, ec(1), 1'(ec(0))};
    vecs[11] = '{0, 1, 1, 0, 0,   0, 1,   0, 1, 0, ec(1), 1'(ec(0))};
    vecs[12] = '{0, 1, 1, 0, 1,   0, 1,   0, 1, 0, ec(0), 1'(ec(0))};
    vecs[13] = '{0, 0, 1, 1, 0,   1, 0,   1, 0, 1, ec(0), 1'(ec(0))};
    vecs[14] = '{1, 1, 1, 1, 1,   0, 1,   0, 0, 0, ec(0), 1'(ec(0))};
    vecs[15] = '{0, 0, 0, 1, 0,   0, 0,   0, 0, 1, ec(0), 1'(ec(0))};

    // Combinational sweep, clock idle.
    bus.en      = 1'b0;
    bus.clr_cnt = 1'b0;
    begin
      logic [1:0] ab_tab [4]  = '{2'b00, 2'b01, 2'b10, 2'b11};
      logic [1:0] exp_tab [4] = '{2'b00, 2'b10, 2'b10, 2'b01}; // {sum,carry}
      for (int i = 0; i < 4; i++) begin
        bus.a = ab_tab[i][1];
        bus.b = ab_tab[i][0];
        #10;
        check("comb_sum",   i, 32'(bus.sum),   32'(exp_tab[i][1]));
        check("comb_carry", i, 32'(bus.carry), 32'(exp_tab[i][0]));
      end
    end

    clk_run = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      rst         = vecs[i].rst;
      bus.a       = vecs[i].a;
      bus.b       = vecs[i].b;
      bus.en      = vecs[i].en;
      bus.clr_cnt = vecs[i].clr;
      @(posedge clk);
      #1;
      check("sum",       i, 32'(bus.sum),       32'(vecs[i].sum));
      check("carry",     i, 32'(bus.carry),     32'(vecs[i].carry));
      check("sum_q",     i, 32'(bus.sum_q),     32'(vecs[i].sq));
      check("carry_q",   i, 32'(bus.carry_q),   32'(vecs[i].cq));
      check("q_valid",   i, 32'(bus.q_valid),   32'(vecs[i].v));
      check("carry_cnt", i, 32'(bus.carry_cnt), 32'(vecs[i].cnt));
      check("cnt_sat",   i, 32'(bus.cnt_sat),   32'(vecs[i].sat));
    end

    // Hand sequence: saturate again, then reset clears the sticky flag.
    @(negedge clk);
    rst = 1'b0; bus.a = 1'b1; bus.b = 1'b1; bus.en = 1'b1; bus.clr_cnt = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("resat_cnt", 0, 32'(bus.carry_cnt), 32'(ec(3)));
    check("resat_sat", 0, 32'(bus.cnt_sat),   32'(ec(1)));
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_cnt", 0, 32'(bus.carry_cnt), 32'd0);
    check("rst_sat", 0, 32'(bus.cnt_sat),   32'd0);
    check("rst_vld", 0, 32'(bus.q_valid),   32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
